// File: rtl/ap_mul_pkg.sv
// ap_mul_pkg: types, step encodings, shift amounts and widths used by
// ap_mul8_seq. It also holds a helper that places a 4x4 partial product at
// its weight inside the 16-bit accumulator.
package ap_mul_pkg;

  localparam int NIB_W  = 4;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] step_t;

  // Bit 1 of the step selects the high nibble of a.
  // Bit 0 of the step selects the high nibble of b.
  localparam step_t STEP_LL = 2'd0;
  localparam step_t STEP_LH = 2'd1;
  localparam step_t STEP_HL = 2'd2;
  localparam step_t STEP_HH = 2'd3;

  localparam int SH_LL  = 0;
  localparam int SH_MID = 4;
  localparam int SH_HH  = 8;

  // Zero-extend the 8-bit partial product, then shift it to the weight of
  // its step. Bits pushed past bit 15 are dropped, so the sum wraps.
  function automatic logic [PROD_W-1:0] place_pp(input logic [2*NIB_W-1:0] p,
                                                 input step_t step);
    logic [PROD_W-1:0] ext;
    ext = {{(PROD_W-2*NIB_W){1'b0}}, p};
    case (step)
      STEP_LL: place_pp = ext << SH_LL;
      STEP_LH: place_pp = ext << SH_MID;
      STEP_HL: place_pp = ext << SH_MID;
      default: place_pp = ext << SH_HH;
    endcase
  endfunction

endpackage

// File: rtl/ap_mul8_seq.sv
// ap_mul8_seq: sequential 8x8 approximate multiplier controller.
// One external 4x4 multiplier is shared across the LL, LH, HL and HH
// partial products. The results are accumulated exactly, modulo 2^16.
//
// Ports:
//   clk, rst_n         clock (rising edge); asynchronous active-low reset
//   in_valid/in_ready  operand handshake; in_a, in_b are the 8-bit operands
//   mul_a, mul_b       nibbles driven to the shared 4x4 multiplier (0 outside CALC)
//   mul_p              combinational 8-bit product returned by that multiplier
//   out_valid/out_ready result handshake; out_prod is the 16-bit product
//   busy               high while computing or holding a result
//
// Parameter SKIP_LL=1 omits the LL partial product. This is a truncated mode
// that needs 3 multiply cycles instead of 4.
module ap_mul8_seq
  import ap_mul_pkg::*;
#(
  parameter bit SKIP_LL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic [NIB_W-1:0]  mul_a,
  output logic [NIB_W-1:0]  mul_b,
  input  logic [2*NIB_W-1:0] mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_prod,
  output logic              busy
);

  state_t              state_reg, state_next;
  step_t               step_reg;
  logic [OP_W-1:0]     a_reg, b_reg;
  logic [PROD_W-1:0]   acc_reg;
  logic [PROD_W-1:0]   prod_reg;
  logic                valid_reg;

  logic                accept;
  logic                last_step;
  logic [PROD_W-1:0]   acc_sum;

  assign accept    = in_valid && in_ready;
  assign last_step = (step_reg == STEP_HH);
  assign acc_sum   = acc_reg + place_pp(mul_p, step_reg);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: begin
        // A new operand pair may be taken on the same edge as the result
        // handshake. This keeps back-to-back operation gap-free.
        if (out_ready) state_next = in_valid ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs derived from the state
  always_comb begin
    in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    busy     = (state_reg != IDLE);
    mul_a    = '0;
    mul_b    = '0;
    if (state_reg == CALC) begin
      mul_a = step_reg[1] ? a_reg[OP_W-1:NIB_W] : a_reg[NIB_W-1:0];
      mul_b = step_reg[0] ? b_reg[OP_W-1:NIB_W] : b_reg[NIB_W-1:0];
    end
  end

  // Datapath: operand capture, partial-product accumulation, result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_reg  <= STEP_LL;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      prod_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        a_reg    <= in_a;
        b_reg    <= in_b;
        acc_reg  <= '0;
        step_reg <= SKIP_LL ? STEP_LH : STEP_LL;
      end else if (state_reg == CALC) begin
        if (last_step) begin
          // The final HH term goes straight into the result. acc_reg is
          // not updated because it is cleared on the next accept.
          prod_reg <= acc_sum;
        end else begin
          acc_reg  <= acc_sum;
          step_reg <= step_reg + 2'd1;
        end
      end

      if ((state_reg == CALC) && last_step) begin
        valid_reg <= 1'b1;
      end else if ((state_reg == DONE) && out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_prod  = prod_reg;

endmodule

// File: doc/ap_mul8_seq.md
Name: ap_mul8_seq

Overview:
Sequential 8x8 approximate multiplier controller. It time-multiplexes a single shared 4x4 approximate multiplier across the four partial products LL, LH, HL and HH, and accumulates them exactly into a 16-bit product. It sits between a valid/ready operand source and a valid/ready result sink. The 4x4 multiplier instance (ap1 or any 4x4 variant) is external and wired through the mul_* ports, so the variant is chosen at the top level.

Parameters:
SKIP_LL, 0, 1 = omit the LL partial product (truncated mode, 3 multiply cycles instead of 4)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands this cycle
in_a  input  8  multiplicand
in_b  input  8  multiplier
mul_a  output  4  nibble to shared 4x4 multiplier, operand a
mul_b  output  4  nibble to shared 4x4 multiplier, operand b
mul_p  input  8  product from shared 4x4 multiplier; combinational, sampled the same cycle
out_valid  output  1  result valid
out_ready  input  1  sink accepts result
out_prod  output  16  accumulated product
busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, step=0, acc=0, operand regs=0, out_valid=0, out_prod=0, busy=0. in_ready=1 after reset deasserts.
- Reset mid-operation aborts the operation immediately. The in-flight result is discarded; nothing is emitted.
- FSM states:
  - IDLE -> CALC on in_valid&&in_ready. On that edge: latch in_a/in_b, acc<=0, step<=(SKIP_LL?1:0).
  - CALC, step 0..3 (2-bit counter):
    - step0 LL: mul_a=a[3:0], mul_b=b[3:0], acc+=mul_p.
    - step1 LH: mul_a=a[3:0], mul_b=b[7:4], acc+=mul_p<<4.
    - step2 HL: mul_a=a[7:4], mul_b=b[3:0], acc+=mul_p<<4.
    - step3 HH: mul_a=a[7:4], mul_b=b[7:4], acc+=mul_p<<8.
    - At step3: out_prod<=acc+(mul_p<<8), out_valid<=1, state<=DONE. Otherwise step<=step+1.
  - DONE: out_valid=1; out_prod held stable until handshake.
    - out_ready=1 and in_valid=1: new operands accepted on the same edge, DONE->CALC.
    - out_ready=1 and in_valid=0: DONE->IDLE.
    - out_valid drops on the handshake edge unless a new result completes on that same edge (cannot happen; minimum CALC is 3 cycles).
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from out_ready.
- mul_a/mul_b = 0 outside CALC.
- Arithmetic: acc is 16 bits unsigned. Partial products are zero-extended, then shifted. The sum wraps modulo 2^16; no saturation. Needed because approximate mul_p may reach 0xFF per nibble pair.
- Latency: out_valid rises 4 edges after the accept edge (3 if SKIP_LL=1).
- Throughput: back-to-back accept from DONE, so one result per 5 cycles (4 if SKIP_LL=1) with out_ready held high.
- in_a/in_b changes after the accept edge have no effect. mul_p is ignored outside CALC.
- out_ready low in DONE: stall indefinitely with no state change.

Decomposition:
- Shared package ap_mul_pkg:
  - state enum {IDLE, CALC, DONE}
  - step encodings STEP_LL=0, STEP_LH=1, STEP_HL=2, STEP_HH=3
  - shift constants SH_LL=0, SH_MID=4, SH_HH=8
  - widths NIB_W=4, OP_W=8, PROD_W=16
- No sub-module inside the block; it is a single FSM plus datapath.
- The verification top instantiates the existing 4x4 multiplier (ap1) on mul_*. The directed tests below use an exact 4x4 behavioural model instead, so the expected values are fixed.

Test Plan:
- Exact model, SKIP_LL=0. Send a=0x12, b=0x34, out_ready=1 -> out_prod=0x03A8 with out_valid exactly 4 edges after accept. mul_a/mul_b sequence (2,4),(2,3),(1,4),(1,3).
- Exact model. Send a=0xFF, b=0xFF -> out_prod=0xFE01. Send a=0x00, b=0xA5 -> 0x0000.
- Exact model, SKIP_LL=1. Send a=0x12, b=0x34 -> out_prod=0x03A0 after 3 edges. mul_a/mul_b never equals (a[3:0], b[3:0]) as step0.
- Model forcing mul_p=0xFF on every step -> out_prod=0x1FDF (wrap of 73695 mod 65536).
- Backpressure and back-to-back:
  - Hold out_ready=0 for 10 cycles in DONE -> out_prod stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 (a=0x03, b=0x05) -> same-edge accept, next out_prod=0x000F.
- Pulse rst_n low during CALC step2 -> all outputs return to reset values asynchronously. No out_valid follows. The next transaction a=0x10, b=0x10 yields 0x0100.
